// File: rtl/write_queue_drain.sv
// Pairs write addresses and write data lines from two independent queues and
// drains them as single-beat memory write requests, one per cycle at full rate.
module write_queue_drain #(
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wreqc_s_valid,
  input  logic [31:0]  wreqc_s_addr,
  output logic         wqfull_1,
  input  logic         wdat_s_valid,
  input  logic [127:0] wdat_s_data,
  output logic         sqfull_1,
  output logic         mem_wvalid,
  input  logic         mem_wready,
  output logic [31:0]  mem_waddr,
  output logic [127:0] mem_wdata,
  output logic         q_ovf_err
);

  localparam int DEPTH = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0]   DEPTH_C   = {1'b1, {QDEPTH_LOG2{1'b0}}};
  localparam logic [QDEPTH_LOG2:0]   CNT_ONE   = {{QDEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [QDEPTH_LOG2:0]   FULL_MARK = DEPTH_C - CNT_ONE;
  localparam logic [QDEPTH_LOG2-1:0] PTR_ONE   = CNT_ONE[QDEPTH_LOG2-1:0];

  typedef enum logic {IDLE, SEND} state_t;

  logic [31:0]  addr_mem [DEPTH];
  logic [127:0] data_mem [DEPTH];

  logic [QDEPTH_LOG2-1:0] a_wr, a_rd, d_wr, d_rd;
  logic [QDEPTH_LOG2:0]   a_cnt, d_cnt;
  state_t                 state;

  logic a_full, d_full, a_push, d_push, both_avail, slot_free, pop;

  assign a_full     = (a_cnt == DEPTH_C);
  assign d_full     = (d_cnt == DEPTH_C);
  assign a_push     = wreqc_s_valid && !a_full;
  assign d_push     = wdat_s_valid && !d_full;
  assign both_avail = (a_cnt != '0) && (d_cnt != '0);
  // The output register is free when idle or when the current beat is accepted
  assign slot_free  = (state == IDLE) || mem_wready;
  assign pop        = both_avail && slot_free;

  // Early-warning flags leave one entry of slack for a registered upstream
  assign wqfull_1 = (a_cnt >= FULL_MARK);
  assign sqfull_1 = (d_cnt >= FULL_MARK);

  always_ff @(posedge clk) begin
    if (a_push) addr_mem[a_wr] <= wreqc_s_addr;
    if (d_push) data_mem[d_wr] <= wdat_s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_wr       <= '0;
      a_rd       <= '0;
      d_wr       <= '0;
      d_rd       <= '0;
      a_cnt      <= '0;
      d_cnt      <= '0;
      state      <= IDLE;
      mem_wvalid <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      q_ovf_err  <= 1'b0;
    end else begin
      if (a_push) a_wr <= a_wr + PTR_ONE;
      if (d_push) d_wr <= d_wr + PTR_ONE;
      if (pop) begin
        a_rd <= a_rd + PTR_ONE;
        d_rd <= d_rd + PTR_ONE;
      end

      case ({a_push, pop})
        2'b10:   a_cnt <= a_cnt + CNT_ONE;
        2'b01:   a_cnt <= a_cnt - CNT_ONE;
        default: a_cnt <= a_cnt;
      endcase
      case ({d_push, pop})
        2'b10:   d_cnt <= d_cnt + CNT_ONE;
        2'b01:   d_cnt <= d_cnt - CNT_ONE;
        default: d_cnt <= d_cnt;
      endcase

      if ((wreqc_s_valid && a_full) || (wdat_s_valid && d_full))
        q_ovf_err <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            mem_waddr  <= addr_mem[a_rd] & ~32'hF;
            mem_wdata  <= data_mem[d_rd];
            mem_wvalid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (mem_wready) begin
            if (pop) begin
              mem_waddr <= addr_mem[a_rd] & ~32'hF;
              mem_wdata <= data_mem[d_rd];
            end else begin
              mem_wvalid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
